// File: rtl/redmule_x_sched.sv
// Scheduler for the RedMulE X buffer: sequences row loads, index reset, pad setup and shifts per tile.
// Optional perf counters (stall_cnt_o, load_wait_o) are built when REDMULE_X_SCHED_PERF_EN is defined.
module redmule_x_sched #(
    parameter int unsigned H     = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned WW   = $clog2(W) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cfg_tiles_i,
    input  logic [WW-1:0]    cfg_width_i,
    input  logic [CNT_W-1:0] cfg_height_i,
    input  logic [CNT_W-1:0] cfg_slots_i,
    input  logic             x_valid_i,
    output logic             x_ready_o,
    input  logic             full_i,
    input  logic             empty_i,
    input  logic             engine_ready_i,
    output logic             load_o,
    output logic             rst_w_index_o,
    output logic             pad_setup_o,
    output logic             h_shift_o,
    output logic [WW-1:0]    width_o,
    output logic [CNT_W-1:0] height_o,
    output logic [CNT_W-1:0] slots_o,
    output logic             busy_o,
    output logic             done_o
`ifdef REDMULE_X_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] load_wait_o
`endif
);

    if (H < 1 || W < 1 || CNT_W < 1) begin : g_param_chk
        $error("redmule_x_sched: H, W and CNT_W must be non-zero");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StAck, StSetup, StCompute, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   tile_cnt_q;
    logic [CNT_W-1:0]   tiles_q;
    logic [WW-1:0]      width_q;
    logic [CNT_W-1:0]   height_q;
    logic [CNT_W-1:0]   slots_q;
    logic               accept;
    logic               empty_cfg;
    logic               tile_done;
    logic               last_tile;
    logic               soft_rst;

    assign soft_rst  = rst_i || clear_i;
    assign accept    = (state_q == StIdle) && start_i;
    assign empty_cfg = (cfg_tiles_i == '0) || (cfg_width_i == '0);
    assign tile_done = (state_q == StCompute) && engine_ready_i && empty_i;
    // Extra bit keeps the compare exact when tiles_q is all-ones.
    assign last_tile = ({1'b0, tile_cnt_q} + 1'b1) == {1'b0, tiles_q};

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_i) state_d = empty_cfg ? StDone : StLoad;
            StLoad:    if (full_i) state_d = StAck;
            StAck:     state_d = (tile_cnt_q == '0) ? StSetup : StCompute;
            StSetup:   state_d = StCompute;
            StCompute: if (tile_done) state_d = last_tile ? StDone : StLoad;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        x_ready_o     = 1'b0;
        load_o        = 1'b0;
        rst_w_index_o = 1'b0;
        pad_setup_o   = 1'b0;
        h_shift_o     = 1'b0;
        done_o        = 1'b0;
        busy_o        = 1'b1;
        unique case (state_q)
            StIdle:    busy_o = 1'b0;
            StLoad: begin
                x_ready_o = !full_i;
                load_o    = x_valid_i && !full_i;
            end
            StAck:     rst_w_index_o = 1'b1;
            StSetup:   pad_setup_o = 1'b1;
            StCompute: h_shift_o = engine_ready_i;
            StDone:    done_o = 1'b1;
            default:   busy_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            tile_cnt_q <= '0;
            tiles_q    <= '0;
            width_q    <= '0;
            height_q   <= '0;
            slots_q    <= '0;
        end else if (accept) begin
            tile_cnt_q <= '0;
            tiles_q    <= cfg_tiles_i;
            width_q    <= cfg_width_i;
            height_q   <= cfg_height_i;
            slots_q    <= cfg_slots_i;
        end else if (tile_done) begin
            tile_cnt_q <= tile_cnt_q + 1'b1;
        end
    end

    assign width_o  = width_q;
    assign height_o = height_q;
    assign slots_o  = slots_q;

`ifdef REDMULE_X_SCHED_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] load_wait_q;

    always_ff @(posedge clk_i) begin
        if (soft_rst || accept) begin
            stall_cnt_q <= '0;
            load_wait_q <= '0;
        end else begin
            if ((state_q == StCompute) && !engine_ready_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if ((state_q == StLoad) && !x_valid_i && (load_wait_q != '1)) begin
                load_wait_q <= load_wait_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign load_wait_o = load_wait_q;
`endif

endmodule

// File: doc/redmule_x_sched.md
REDMULE_X_SCHED -- requirements
Module: redmule_x_sched

Interface
REQ-001 Parameter H, default ARRAY_HEIGHT, PE rows per column (h_shift cadence base).
REQ-002 Parameter W, default ARRAY_WIDTH, max X rows loaded per tile.
REQ-003 Parameter CNT_W, default 16, width of tile/slot/stat counters.
REQ-004 The block SHALL have one clock and a synchronous active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-005 Ports: clear_i  in  1  sync soft clear; start_i  in  1  job start pulse; cfg_tiles_i  in  CNT_W  tiles per job; cfg_width_i  in  $clog2(W)+1  rows per tile; cfg_height_i  in  CNT_W  valid pad rows; cfg_slots_i  in  CNT_W  pad slots used.
REQ-006 Ports: x_valid_i  in  1  streamer row valid; x_ready_o  out  1  row accepted; full_i  in  1  X buffer full flag; empty_i  in  1  X buffer empty flag; engine_ready_i  in  1  array can consume a shift.
REQ-007 Ports: load_o, rst_w_index_o, pad_setup_o, h_shift_o  out  1 each  X buffer controls; width_o  out  $clog2(W)+1; height_o, slots_o  out  CNT_W  latched config; busy_o, done_o  out  1  status.

Function
REQ-008 FSM states SHALL be IDLE, LOAD, ACK, SETUP, COMPUTE, DONE.
REQ-009 IDLE: start_i SHALL latch all cfg_* inputs and go to LOAD; start_i in any other state SHALL be ignored.
REQ-010 start_i with cfg_tiles_i==0 or cfg_width_i==0 SHALL go directly to DONE with no load_o/h_shift_o pulses.
REQ-011 LOAD: x_ready_o=1 while full_i==0; load_o SHALL equal x_valid_i && x_ready_o in the same cycle (zero latency).
REQ-012 LOAD: full_i==1 SHALL force x_ready_o=0 and transition to ACK.
REQ-013 ACK: rst_w_index_o SHALL pulse exactly one cycle; next state SETUP for tile 0, else COMPUTE.
REQ-014 SETUP: pad_setup_o SHALL pulse exactly one cycle, then COMPUTE.
REQ-015 COMPUTE: h_shift_o SHALL equal engine_ready_i; no other control output asserted.
REQ-016 COMPUTE: empty_i==1 (coincident with h_shift_o) SHALL increment tile_cnt; if tile_cnt+1==cfg_tiles go to DONE, else LOAD.
REQ-017 DONE: done_o SHALL pulse one cycle, then IDLE.
REQ-018 busy_o SHALL be 1 in every state except IDLE; width_o/height_o/slots_o SHALL hold latched values until next accepted start_i.
REQ-019 load_o, rst_w_index_o, pad_setup_o, h_shift_o SHALL never be asserted in the same cycle as each other.
REQ-020 tile_cnt SHALL be CNT_W bits, reset to 0 on start_i acceptance, never wrap within a job (cfg_tiles max 2^CNT_W-1).
REQ-021 full_i and x_valid_i high in the same LOAD cycle: the row SHALL NOT be accepted (x_ready_o=0).

Reset
REQ-022 rst_i or clear_i SHALL, at the next clock edge, return the FSM to IDLE, zero tile_cnt, latched config and stat counters.
REQ-023 Reset values: all outputs 0; a reset mid-job SHALL suppress any pending pulse and SHALL NOT produce done_o.

Configuration
REQ-024 Macro REDMULE_X_SCHED_PERF_EN: when defined, ports stall_cnt_o (CNT_W, cycles in COMPUTE with engine_ready_i==0) and load_wait_o (CNT_W, cycles in LOAD with x_valid_i==0) SHALL exist, saturate at all-ones, clear on start_i acceptance and reset.
REQ-025 Without REDMULE_X_SCHED_PERF_EN the ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-026 W=8, cfg_tiles=1, cfg_width=8, x_valid_i always 1: 8 load_o pulses, full_i -> 1 rst_w_index_o, 1 pad_setup_o, h_shift_o follows engine_ready_i, empty_i -> done_o one cycle later.
REQ-027 cfg_tiles=3: pad_setup_o exactly once; rst_w_index_o exactly 3 times; done_o after 3rd empty_i.
REQ-028 start_i with cfg_tiles=0: DONE next cycle, done_o=1 once, zero load_o.
REQ-029 x_valid_i toggling 1/0 in LOAD, full_i asserted with x_valid_i=1: that row not accepted, load_o count equals cfg_width.
REQ-030 rst_i asserted in COMPUTE mid-tile: next cycle all outputs 0, busy_o=0, no done_o; new start_i runs a clean job.
REQ-031 PERF_EN build, engine_ready_i low 5 cycles in COMPUTE: stall_cnt_o==5; cleared by next start_i.
